// File: rtl/sc_stream_ctrl.sv
// Sequencer + keystream XOR for the 384-bit stream-cipher state block; optional SC_BYTE_MASK_EN adds pt_bytes masking.
// Latency: INIT..POST = INIT_ROUNDS+1+POST_ROUNDS cycles, then pt->ct 1 cycle, 1 word/cycle sustained.
// Backpressure: pt_ready = !ct_valid | ct_ready in STREAM only; ct word held stable while ct_valid & !ct_ready.
module sc_stream_ctrl #(
    parameter int INIT_ROUNDS = 18,
    parameter int POST_ROUNDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        load_SC64,
    output logic        insertSC,
    input  logic [63:0] Z,
    input  logic [63:0] pt_data,
    input  logic        pt_valid,
    input  logic        pt_last,
`ifdef SC_BYTE_MASK_EN
    input  logic [3:0]  pt_bytes,
`endif
    output logic        pt_ready,
    output logic [63:0] ct_data,
    output logic        ct_valid,
    output logic        ct_last,
    input  logic        ct_ready,
    output logic        busy,
    output logic        done
);

    localparam int MAX_ROUNDS = (INIT_ROUNDS > POST_ROUNDS) ? INIT_ROUNDS : POST_ROUNDS;
    localparam int CW         = $clog2(MAX_ROUNDS + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_ROUNDS - 1);
    localparam logic [CW-1:0] POST_LAST = (POST_ROUNDS > 0) ? CW'(POST_ROUNDS - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_INSERT = 3'd2,
        S_POST   = 3'd3,
        S_STREAM = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic [63:0]   mask;

    // State and round counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, round counting and control strobes; Z is consumed only on a pt handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_SC64 = 1'b0;
        insertSC  = 1'b0;
        pt_ready  = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                end
            end
            S_INIT: begin
                load_SC64 = 1'b1;
                if (cnt == INIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_INSERT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_INSERT: begin
                insertSC  = 1'b1;
                state_nxt = (POST_ROUNDS == 0) ? S_STREAM : S_POST;
            end
            S_POST: begin
                load_SC64 = 1'b1;
                if (cnt == POST_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_STREAM;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_STREAM: begin
                pt_ready  = !ct_valid || ct_ready;
                accept    = pt_valid && pt_ready;
                load_SC64 = accept;
                if (accept && pt_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (ct_valid && ct_ready) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SC_BYTE_MASK_EN
    logic [3:0] nbytes;

    // Keep the first nbytes bytes (MSB end) of the accepted word; 0 or >8 means full word
    always_comb begin
        nbytes = ((pt_bytes == 4'd0) || (pt_bytes > 4'd8)) ? 4'd8 : pt_bytes;
        mask   = '0;
        for (int i = 0; i < 8; i++) begin
            mask[63 - 8*i -: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
        end
    end
`else
    // Every word is a full 64-bit XOR
    always_comb begin
        mask = '1;
    end
`endif

    // Ciphertext output register: load on accept, clear valid on drain, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_data  <= '0;
            ct_valid <= 1'b0;
            ct_last  <= 1'b0;
        end else if (accept) begin
            ct_data  <= (pt_data ^ Z) & mask;
            ct_valid <= 1'b1;
            ct_last  <= pt_last;
        end else if (ct_valid && ct_ready) begin
            ct_valid <= 1'b0;
            ct_last  <= 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// Scoreboard bench for sc_stream_ctrl: directed messages, a keystream model, a ct monitor.
// Latency checked cycle by cycle through INIT/INSERT/POST; ct compared on each handshake.
// Backpressure exercised by dropping ct_ready mid-burst and checking ct hold stability.
module tb_sc_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_SC64;
    logic        insertSC;
    logic [63:0] Z;
    logic [63:0] pt_data;
    logic        pt_valid;
    logic        pt_last;
`ifdef SC_BYTE_MASK_EN
    logic [3:0]  pt_bytes;
`endif
    logic        pt_ready;
    logic [63:0] ct_data;
    logic        ct_valid;
    logic        ct_last;
    logic        ct_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sc_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_SC64 (load_SC64),
        .insertSC  (insertSC),
        .Z         (Z),
        .pt_data   (pt_data),
        .pt_valid  (pt_valid),
        .pt_last   (pt_last),
`ifdef SC_BYTE_MASK_EN
        .pt_bytes  (pt_bytes),
`endif
        .pt_ready  (pt_ready),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_last   (ct_last),
        .ct_ready  (ct_ready),
        .busy      (busy),
        .done      (done)
    );

    // Keystream model of the state block: Z is a function of the number of 64-round advances
    logic [31:0] ks_idx;
    logic        ks_clr;
    logic        z_force;
    logic [63:0] z_val;

    function automatic logic [63:0] zfun(input logic [31:0] k);
        return {k * 32'h9E37_79B9, ~k};
    endfunction

    always @(posedge clk) begin
        if (ks_clr)         ks_idx <= 32'd0;
        else if (load_SC64) ks_idx <= ks_idx + 32'd1;
    end

    assign Z = z_force ? z_val : zfun(ks_idx);

    typedef struct {
        logic [63:0] d;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int stalls = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every ct handshake, checks hold stability and strobe exclusivity
    initial begin
        logic        hold_vld;
        logic [63:0] hold_dat;
        exp_t        e;
        hold_vld = 1'b0;
        hold_dat = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                hold_vld = 1'b0;
            end else begin
                if (load_SC64) load_cnt++;
                if (load_SC64 || insertSC) chk("strobe_excl", load_SC64 & insertSC, 0);
                if (hold_vld) begin
                    chk("ct_hold_data", ct_data, hold_dat);
                    chk("ct_hold_valid", ct_valid, 1);
                end
                hold_vld = ct_valid && !ct_ready;
                hold_dat = ct_data;
                if (ct_valid && ct_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_ct", ct_data, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ct_data", ct_data, e.d);
                        chk("ct_last", ct_last, e.l);
                        chk("done_on_last", done, e.l);
                    end
                end else if (done) begin
                    chk("done_spurious", done, 0);
                end
                if (done) done_cnt++;
            end
        end
    end

    // Pulse start and trace the 22 cycles of INIT/INSERT/POST up to pt_ready
    task automatic start_trace();
        logic [3:0] ev;
        start  = 1'b1;
        ks_clr = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ks_clr = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            #1;
            ev[3] = 1'b1;
            ev[2] = (k <= 18) || (k == 20) || (k == 21);
            ev[1] = (k == 19);
            ev[0] = (k == 22);
            chk($sformatf("seq_busy_load_ins_rdy_c%0d", k), {busy, load_SC64, insertSC, pt_ready}, ev);
            @(negedge clk);
        end
    endtask

    // Offer one pt word; expectation is pushed when the handshake is seen
    task automatic send(input logic [63:0] d, input logic l, input logic use_z, input logic [63:0] e);
        int n;
        n        = 0;
        pt_data  = d;
        pt_last  = l;
        pt_valid = 1'b1;
        #1;
        while (!pt_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!pt_ready) begin
            chk("pt_accept_timeout", 0, 1);
        end else begin
            exp_q.push_back('{d: (use_z ? (d ^ Z) : e), l: l});
        end
        @(negedge clk);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("done_reached", done_cnt >= target, 1);
        @(negedge clk);
        #1;
        chk("idle_after_done", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        int snap;
        int dsnap;
        logic [63:0] burst [4];
        burst[0] = 64'hA5A5_0000_1111_2222;
        burst[1] = 64'h0F0F_3333_4444_5555;
        burst[2] = 64'hDEAD_BEEF_CAFE_F00D;
        burst[3] = 64'h1234_5678_9ABC_DEF0;

        rst      = 1'b0;
        start    = 1'b0;
        ks_clr   = 1'b1;
        z_force  = 1'b0;
        z_val    = '0;
        pt_data  = '0;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        ct_ready = 1'b1;
`ifdef SC_BYTE_MASK_EN
        pt_bytes = 4'd8;
`endif
        #3;
        chk("reset_outputs", {load_SC64, insertSC, pt_ready, ct_data, ct_valid, ct_last, busy, done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        ks_clr = 1'b0;
        @(negedge clk);

        // Init sequence, then a single forced-Z word
        start_trace();
        z_force = 1'b1;
        z_val   = 64'hFFFF_0000_FFFF_0000;
        send(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 64'hFEDC_4567_7654_CDEF);
        z_force = 1'b0;
        wait_done(1);

        // 4-word burst with ct_ready low for 3 cycles mid-burst
        start_trace();
        snap   = load_cnt;
        stalls = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(burst[i], (i == 3), 1'b1, '0);
            end
            begin
                repeat (2) @(negedge clk);
                ct_ready = 1'b0;
                repeat (3) @(negedge clk);
                ct_ready = 1'b1;
            end
        join
        wait_done(2);
        chk("stream_load_count", load_cnt - snap, 4);
        chk("pt_ready_dropped", stalls > 0, 1);

`ifdef SC_BYTE_MASK_EN
        // Byte masking with zero keystream
        start_trace();
        z_force  = 1'b1;
        z_val    = '0;
        pt_bytes = 4'd3;
        send(64'h1122_3344_5566_7788, 1'b1, 1'b0, 64'h1122_3300_0000_0000);
        pt_bytes = 4'd8;
        z_force  = 1'b0;
        wait_done(3);
`endif

        // Reset asserted during INIT round 7
        dsnap  = done_cnt;
        start  = 1'b1;
        ks_clr = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ks_clr = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("init_r7_load", load_SC64, 1);
        rst = 1'b0;
        #1;
        chk("midop_reset_outputs", {load_SC64, insertSC, pt_ready, ct_data, ct_valid, ct_last, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_trace();
        send(64'h5555_AAAA_0F0F_F0F0, 1'b1, 1'b1, '0);
        wait_done(dsnap + 1);
        chk("no_done_from_aborted", done_cnt - dsnap, 1);

        // start pulsed during STREAM is ignored
        start_trace();
        send(64'h0000_1111_2222_3333, 1'b0, 1'b1, '0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_in_stream", {busy, load_SC64, insertSC, pt_ready}, 4'b1001);
        @(negedge clk);
        #1;
        chk("start_in_stream_2", {busy, load_SC64, insertSC, pt_ready}, 4'b1001);
        @(negedge clk);
        send(64'h4444_5555_6666_7777, 1'b1, 1'b1, '0);
        wait_done(dsnap + 2);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
